// File: rtl/audio_flash_writer.sv
`default_nettype none
// ============================================================================
//  Module   : audio_flash_writer
//  Purpose  : Record-path capture engine. Packs pairs of 16-bit audio samples
//             into 32-bit words (earlier sample in [15:0]) and writes them to
//             sequential flash word addresses as an Avalon-MM write master.
//             A one-sample pending buffer absorbs a strobe that arrives while
//             a write is stalled; further strobes are dropped and flagged.
//  Ports    : clk          - system clock
//             rst_n        - synchronous active-low reset
//             start        - one-cycle pulse, begins a recording (IDLE/DONE)
//             sample_valid - one-cycle strobe qualifying sample
//             sample       - 16-bit signed audio sample
//             waitrequest  - Avalon slave stall
//             write        - Avalon write request
//             address      - 23-bit word address
//             writedata    - packed sample pair
//             byteenable   - constant 4'b1111
//             busy         - high while capturing or writing
//             done         - high once the last word has been accepted
//             overrun      - sticky, a sample was dropped in this recording
//  Revision : 1.0  initial release
// ============================================================================
module audio_flash_writer #(
   parameter logic [22:0] START_ADDR = 23'h000000,
   parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        sample_valid,
   input  logic [15:0] sample,
   input  logic        waitrequest,
   output logic        write,
   output logic [22:0] address,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [3:0] c_BYTE_EN_ALL = 4'b1111;

   state_t      r_state;
   logic        r_half;        // low half of the current pair is held in r_lo
   logic [15:0] r_lo;
   logic        r_pend_full;   // a sample is parked in r_pend during a stall
   logic [15:0] r_pend;
   logic        r_write;
   logic [22:0] r_address;
   logic [31:0] r_writedata;
   logic        r_busy;
   logic        r_done;
   logic        r_overrun;

   logic        w_accept;
   logic        w_last;

   assign w_accept = r_write & ~waitrequest;
   assign w_last   = (r_address == END_ADDR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_half      <= 1'b0;
         r_lo        <= 16'd0;
         r_pend_full <= 1'b0;
         r_pend      <= 16'd0;
         r_write     <= 1'b0;
         r_address   <= START_ADDR;
         r_writedata <= 32'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         case (r_state)
            // A strobe coinciding with start is deliberately not captured.
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state     <= ST_CAPTURE;
                  r_address   <= START_ADDR;
                  r_half      <= 1'b0;
                  r_pend_full <= 1'b0;
                  r_overrun   <= 1'b0;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
               end
            end

            ST_CAPTURE: begin
               if (sample_valid) begin
                  if (!r_half) begin
                     r_lo   <= sample;
                     r_half <= 1'b1;
                  end else begin
                     r_writedata <= {sample, r_lo};
                     r_write     <= 1'b1;
                     r_half      <= 1'b0;
                     r_state     <= ST_WRITE;
                  end
               end
            end

            ST_WRITE: begin
               // A strobe finding the pending slot occupied is lost, even on
               // the acceptance edge.
               if (sample_valid && r_pend_full) begin
                  r_overrun <= 1'b1;
               end

               if (w_accept) begin
                  r_write     <= 1'b0;
                  r_pend_full <= 1'b0;
                  if (w_last) begin
                     // Recording complete; any parked sample is discarded.
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_half  <= 1'b0;
                  end else begin
                     r_address <= r_address + 23'd1;
                     r_state   <= ST_CAPTURE;
                     // The pending sample (or a strobe landing on the
                     // acceptance edge into an empty slot) moves straight
                     // into the low half, so the first CAPTURE cycle can
                     // already complete the next pair.
                     if (r_pend_full) begin
                        r_lo   <= r_pend;
                        r_half <= 1'b1;
                     end else if (sample_valid) begin
                        r_lo   <= sample;
                        r_half <= 1'b1;
                     end else begin
                        r_half <= 1'b0;
                     end
                  end
               end else if (sample_valid && !r_pend_full) begin
                  r_pend      <= sample;
                  r_pend_full <= 1'b1;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign write      = r_write;
   assign address    = r_address;
   assign writedata  = r_writedata;
   assign byteenable = c_BYTE_EN_ALL;
   assign busy       = r_busy;
   assign done       = r_done;
   assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_flash_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_flash_writer
//  Purpose  : Self-checking bench for audio_flash_writer. Directed scenarios
//             followed by randomized traffic, all compared every cycle
//             against a queue-based reference model of the recorder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_audio_flash_writer;

   localparam logic [22:0] START_ADDR = 23'h000010;
   localparam logic [22:0] END_ADDR   = 23'h000012;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sample_valid;
   logic [15:0] sample;
   logic        waitrequest;
   logic        write;
   logic [22:0] address;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        busy;
   logic        done;
   logic        overrun;

   audio_flash_writer #(
      .START_ADDR (START_ADDR),
      .END_ADDR   (END_ADDR)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .sample_valid (sample_valid),
      .sample       (sample),
      .waitrequest  (waitrequest),
      .write        (write),
      .address      (address),
      .writedata    (writedata),
      .byteenable   (byteenable),
      .busy         (busy),
      .done         (done),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A recording is "active" from start until the last word is accepted.
   // Samples collect in a queue; two queued samples make a word. While a
   // word is outstanding, only one further sample may wait in the queue.
   bit          m_active;
   bit          m_done;
   bit          m_inflight;
   bit          m_overrun;
   logic [22:0] m_addr;
   logic [31:0] m_wdata;
   logic [15:0] m_q[$];

   task automatic model_step();
      if (!rst_n) begin
         m_active   = 0;
         m_done     = 0;
         m_inflight = 0;
         m_overrun  = 0;
         m_addr     = START_ADDR;
         m_wdata    = 32'd0;
         m_q.delete();
      end else if (!m_active) begin
         if (start) begin
            m_active  = 1;
            m_done    = 0;
            m_addr    = START_ADDR;
            m_overrun = 0;
            m_q.delete();
         end
      end else if (m_inflight) begin
         if (sample_valid) begin
            if (m_q.size() == 0) m_q.push_back(sample);
            else                 m_overrun = 1;
         end
         if (!waitrequest) begin
            m_inflight = 0;
            if (m_addr == END_ADDR) begin
               m_active = 0;
               m_done   = 1;
               m_q.delete();
            end else begin
               m_addr = m_addr + 23'd1;
            end
         end
      end else if (sample_valid) begin
         m_q.push_back(sample);
         if (m_q.size() == 2) begin
            m_wdata    = {m_q[1], m_q[0]};
            m_inflight = 1;
            m_q.delete();
         end
      end
   endtask

   task automatic compare_all();
      check_val("write",      32'(write),      32'(m_inflight));
      check_val("address",    32'(address),    32'(m_addr));
      check_val("writedata",  writedata,       m_wdata);
      check_val("byteenable", 32'(byteenable), 32'hF);
      check_val("busy",       32'(busy),       32'(m_active));
      check_val("done",       32'(done),       32'(m_done));
      check_val("overrun",    32'(overrun),    32'(m_overrun));
   endtask

   // One clock: apply inputs, let the edge happen, advance model, compare.
   task automatic cycle(input logic rn, input logic st, input logic sv,
                        input logic [15:0] s, input logic wr);
      rst_n        = rn;
      start        = st;
      sample_valid = sv;
      sample       = s;
      waitrequest  = wr;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_cyc(input logic wr);
      cycle(1'b1, 1'b0, 1'b0, 16'h0000, wr);
   endtask

   task automatic strobe(input logic [15:0] s, input logic wr);
      cycle(1'b1, 1'b0, 1'b1, s, wr);
   endtask

   task automatic pulse_start();
      cycle(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
   endtask

   int stall_left;
   logic r_rn, r_st, r_sv, r_wr;

   initial begin
      rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0;
      sample = 16'h0; waitrequest = 1'b0;

      // Reset and ignored IDLE strobes (including one alongside start)
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      check_val("rst_address", 32'(address), 32'h10);
      check_val("rst_busy",    32'(busy),    32'h0);
      strobe(16'h5555, 1'b0);
      strobe(16'h6666, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 16'h7777, 1'b0);

      // Basic pairing
      strobe(16'h1111, 1'b0);
      strobe(16'h2222, 1'b0);
      check_val("pair0_write", 32'(write),    32'h1);
      check_val("pair0_addr",  32'(address),  32'h10);
      check_val("pair0_data",  writedata,     32'h2222_1111);
      idle_cyc(1'b0);
      strobe(16'h3333, 1'b0);
      strobe(16'h4444, 1'b0);
      check_val("pair1_addr",  32'(address),  32'h11);
      check_val("pair1_data",  writedata,     32'h4444_3333);
      idle_cyc(1'b0);

      // start with half=1 must not disturb the pair or address
      strobe(16'h5A5A, 1'b0);
      pulse_start();
      strobe(16'h6B6B, 1'b0);
      check_val("midstart_addr", 32'(address), 32'h12);
      check_val("midstart_data", writedata,    32'h6B6B_5A5A);
      idle_cyc(1'b0);
      check_val("end_done", 32'(done), 32'h1);
      check_val("end_busy", 32'(busy), 32'h0);
      strobe(16'h1234, 1'b0);
      strobe(16'h5678, 1'b0);
      idle_cyc(1'b0);

      // Long stall with one pending sample
      pulse_start();
      check_val("restart_addr", 32'(address), 32'h10);
      strobe(16'h0101, 1'b0);
      strobe(16'h0202, 1'b1);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) strobe(16'hAAAA, 1'b1);
         else        idle_cyc(1'b1);
         check_val("stall_addr", 32'(address), 32'h10);
         check_val("stall_data", writedata,    32'h0202_0101);
      end
      idle_cyc(1'b0);
      strobe(16'hBBBB, 1'b0);
      check_val("pend_data",    writedata,     32'hBBBB_AAAA);
      check_val("pend_addr",    32'(address),  32'h11);
      check_val("pend_overrun", 32'(overrun),  32'h0);
      idle_cyc(1'b0);
      strobe(16'h0505, 1'b0);
      strobe(16'h0606, 1'b0);
      idle_cyc(1'b0);

      // Overrun: two strobes during one stall
      pulse_start();
      strobe(16'h0303, 1'b0);
      strobe(16'h0404, 1'b1);
      idle_cyc(1'b1);
      strobe(16'hDDDD, 1'b1);
      idle_cyc(1'b1);
      strobe(16'hEEEE, 1'b1);
      check_val("ovr_set", 32'(overrun), 32'h1);
      idle_cyc(1'b1);
      idle_cyc(1'b0);
      strobe(16'hFFFF, 1'b1);
      check_val("ovr_next_data", writedata, 32'hFFFF_DDDD);
      idle_cyc(1'b0);
      strobe(16'h0707, 1'b0);
      strobe(16'h0808, 1'b0);
      idle_cyc(1'b0);
      pulse_start();
      check_val("ovr_clear", 32'(overrun), 32'h0);

      // Reset during a stalled write
      strobe(16'h0909, 1'b0);
      strobe(16'h0A0A, 1'b1);
      idle_cyc(1'b1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      check_val("rstmid_write", 32'(write),   32'h0);
      check_val("rstmid_busy",  32'(busy),    32'h0);
      check_val("rstmid_addr",  32'(address), 32'h10);
      for (int i = 0; i < 4; i++) strobe(16'(i + 1), 1'b0);

      // Randomized traffic
      stall_left = 0;
      for (int i = 0; i < 4000; i++) begin
         r_rn = ($urandom_range(0, 499) != 0);
         r_st = ($urandom_range(0, 39) == 0);
         r_sv = ($urandom_range(0, 1) == 1);
         if (stall_left > 0) begin
            r_wr = 1'b1;
            stall_left--;
         end else if ($urandom_range(0, 7) == 0) begin
            stall_left = $urandom_range(1, 25);
            r_wr = 1'b1;
         end else begin
            r_wr = ($urandom_range(0, 2) == 0);
         end
         cycle(r_rn, r_st, r_sv, 16'($urandom), r_wr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/audio_flash_writer.md
# audio_flash_writer

Capture engine for the record path of the audio player. It accepts a stream of signed 16-bit audio samples on single-cycle strobes and packs each pair into one 32-bit word, earlier sample in bits [15:0]. It writes the words to sequential flash word addresses as an Avalon-MM write master with waitrequest, so the existing flash read path can play the recording back. A one-sample holding buffer absorbs samples that arrive while a write is stalled; overflow of that buffer is flagged.

## Interface
- START_ADDR, 23'h000000, first word address written after `start`
- END_ADDR, 23'h07FFFF, last word address written; the recording stops after this word is accepted
- clk  in  1  system clock (50 MHz domain)
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  one-cycle pulse; begins a recording from IDLE or DONE
- sample_valid  in  1  one-cycle strobe qualifying `sample`
- sample  in  16  signed audio sample
- waitrequest  in  1  Avalon slave stall
- write  out  1  Avalon write request
- address  out  23  word address
- writedata  out  32  packed sample pair
- byteenable  out  4  constant 4'b1111
- busy  out  1  high in CAPTURE and WRITE
- done  out  1  high in DONE
- overrun  out  1  sticky; a sample was dropped during the current recording

## Operation
- All outputs are registered. Reset values: write=0, address=START_ADDR, writedata=0, busy=0, done=0, overrun=0. The state is IDLE and the half flag and pending flag are cleared. byteenable is always 4'b1111.
- **IDLE**
  - On `start`: address←START_ADDR, half←0, pending←0, overrun←0, go to CAPTURE.
  - `sample_valid` is ignored, including when it coincides with `start`.
- **CAPTURE**
  - On `sample_valid` with half=0: lo←sample, half←1.
  - On `sample_valid` with half=1: writedata←{sample, lo}, write←1, half←0, go to WRITE.
- **WRITE**
  - address, writedata and write are held stable while waitrequest=1.
  - The word is accepted on the rising edge where write=1 and waitrequest=0. On that edge write←0.
  - If address==END_ADDR, go to DONE and leave address unchanged. Otherwise address←address+1 and go to CAPTURE.
- **Pending buffer**
  - Any `sample_valid` seen in WRITE, including on the acceptance edge, is stored in the pending register if it is empty.
  - If the register is already full, the new sample is dropped and overrun←1.
  - On entry to CAPTURE with pending full: lo←pending, half←1, pending←0.
  - A `sample_valid` on that same CAPTURE-entry cycle is then the high half.
- **DONE**
  - done=1 and write=0. The state holds until `start`, which restarts the recording exactly as from IDLE.
  - Any pending or odd sample is discarded.
- `start` is ignored while busy=1.
- Address arithmetic is 23-bit unsigned. END_ADDR must be ≥ START_ADDR, so the address never wraps within a recording.
- Reset asserted mid-transfer aborts the write immediately. The slave must tolerate write being withdrawn under waitrequest; the flash controller allows this on reset only.

## Timing
- write rises on the clock edge that samples the second `sample_valid` of a pair, i.e. one cycle after the strobe is presented.
- With waitrequest=0, each write lasts exactly 1 cycle. The minimum spacing between writes is 2 cycles, because a new pair is required.
- busy rises on the edge that samples `start`. done rises on the acceptance edge of the END_ADDR word, and busy falls on that same edge.
- overrun is set on the edge that samples the dropped strobe. It clears only on `start` or on reset.
- rst_n low is sampled on a clk edge; all outputs take their reset values on that edge.

## Test plan
- **Basic pairing.** Reset, pulse `start`, then strobe samples 16'h1111 and 16'h2222 with waitrequest=0. Expect one write with address=0 and writedata=32'h2222_1111. The next pair 16'h3333, 16'h4444 gives address=1 and writedata=32'h4444_3333.
- **Waitrequest stall and pending buffer.** Hold waitrequest=1 for 20 cycles during a write and strobe one sample 16'hAAAA mid-stall. Expect address and writedata stable for all 20 cycles. After acceptance, one further strobe 16'hBBBB must produce writedata=32'hBBBB_AAAA with overrun=0.
- **Overrun.** During the same stall, strobe two samples. Expect overrun=1 on the second strobe and the second sample absent from every later word. The next word uses the first stalled sample as its low half.
- **End of recording.** Use START_ADDR=23'h10 and END_ADDR=23'h12. Six samples produce writes at addresses 10, 11 and 12, then done=1 and busy=0. Further strobes produce no writes. A new `start` resets address to 23'h10 and clears overrun.
- **Ignored inputs.** Apply `sample_valid` in IDLE, and `start` while in CAPTURE with half=1. Expect no writes from the IDLE strobes, and the address and the half-word unchanged by the mid-record `start`.
- **Reset mid-operation.** Drive rst_n=0 while write=1 and waitrequest=1. On the next edge expect write=0, busy=0, address=START_ADDR, and overrun=0. No write occurs afterward until `start`.
